multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready per access; 0 disables the timeout.
REQ-002 SHALL have parameter RETIRE_W, default 32: width of retire_count.
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
REQ-006 SHALL have port mem_ready  in  1  memory completes the current request this cycle.
REQ-007 SHALL have port branch_taken  in  1  ALU branch-condition result; sampled in EXEC.
REQ-008 SHALL have port mem_req  out  1  memory access request.
REQ-009 SHALL have port mem_we  out  1  store qualifier for mem_req.
REQ-010 SHALL have ports ir_write, pc_write, reg_write  out  1 each  register write enables.
REQ-011 SHALL have ports alu_src_a, alu_src_b, wb_sel  out  2 each  datapath mux selects.
REQ-012 SHALL have port alu_op  out  2  00 add, 01 branch-compare, 10 funct-decoded.
REQ-013 SHALL have ports illegal, timeout_err  out  1 each  sticky fault flags.
REQ-014 SHALL have ports retire  out  1  and retire_count  out  RETIRE_W.

Function
REQ-015 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, TRAP in a single registered state variable.
REQ-016 SHALL classify opcode as R (0110011), LOAD (0000011), IMM (0010011), STORE (0100011), BRANCH (1100011), JAL (1101111), LUI (0110111), AUIPC (0010111), or ILLEGAL for any other value.
REQ-017 SHALL latch the class in DECODE and hold it until the next DECODE.
REQ-018 In FETCH: mem_req=1, mem_we=0; when mem_ready=1, ir_write=1 and pc_write=1 (PC+4) in the same cycle, then go to DECODE.
REQ-019 In DECODE, a one-cycle state: go to TRAP with illegal=1 if the class is ILLEGAL, else go to EXEC.
REQ-020 In EXEC: R and IMM (alu_op=10), LUI, AUIPC and JAL go to WB; LOAD and STORE (alu_op=00) go to MEM.
REQ-021 For BRANCH in EXEC: alu_op=01, pc_write=branch_taken, retire=1, then go to FETCH.
REQ-022 For JAL in EXEC: pc_write=1 to the jump target.
REQ-023 In MEM: mem_req=1, mem_we=1 for STORE; on mem_ready, STORE sets retire=1 and goes to FETCH, LOAD goes to WB.
REQ-024 In WB: reg_write=1 and retire=1 for one cycle, then go to FETCH.
REQ-025 wb_sel SHALL be 00 ALU, 01 memory (LOAD), 10 PC+4 (JAL).
REQ-026 Outputs SHALL be decoded from state and latched class; ir_write, pc_write in FETCH and retire in MEM additionally depend on mem_ready in the same cycle.
REQ-027 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
REQ-028 If MEM_TIMEOUT>0 and the wait counter reaches MEM_TIMEOUT with mem_ready still 0, SHALL go to TRAP with timeout_err=1.
REQ-029 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL win: no timeout.
REQ-030 TRAP SHALL be absorbing until reset, with all enables and mem_req low.
REQ-031 retire_count SHALL increment by 1 per retire pulse and wrap modulo 2^RETIRE_W.
REQ-032 No write enable SHALL be active in DECODE or TRAP.

Reset
REQ-033 While rst_n=0: state=FETCH; counters, class, illegal and timeout_err are 0.
REQ-034 Assertion of rst_n SHALL act immediately (asynchronously), aborting any in-flight access; mem_req drops combinationally.
REQ-035 After rst_n deasserts, the first cycle SHALL be FETCH with mem_req=1.

Structure
REQ-036 Package ctrl_pkg SHALL hold the state enum, the instruction-class enum, the opcode constants, and the alu_op/wb_sel/src encodings.
REQ-037 Opcode-to-class decoding SHALL be a separate combinational sub-module, opcode_classifier.

Verification
REQ-038 Reset, then mem_ready tied 1, opcode=0110011 -> states FETCH, DECODE, EXEC, WB; reg_write high in cycle 4 only; retire_count=1.
REQ-039 opcode=0000011, mem_ready low 3 cycles in MEM -> mem_req held 4 MEM cycles, wb_sel=01 in WB; total 8 cycles to retire.
REQ-040 opcode=1100011, branch_taken=0 then 1 -> pc_write low then high in EXEC; 3 cycles per branch; no reg_write.
REQ-041 opcode=1111111 -> TRAP after DECODE, illegal=1, all enables low for 20 further cycles.
REQ-042 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP and timeout_err=1 on the 5th FETCH cycle; a repeat run with mem_ready on the 5th FETCH cycle -> no fault.
REQ-043 rst_n pulsed low mid-MEM of a store -> mem_req low immediately; retire_count=0; FETCH on release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// instruction classes, opcode constants and datapath select encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // CLS_ILLEGAL is the zero encoding so a reset class register reads as "nothing decoded".
  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_R       = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_IMM     = 4'd3,
    CLS_STORE   = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8
  } class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  function automatic logic is_mem_class(input class_e c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Pure combinational mapping from the 7-bit major opcode to an instruction class.
module opcode_classifier
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [3:0] op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_R:      op_class = CLS_R;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_IMM:    op_class = CLS_IMM;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_JAL:    op_class = CLS_JAL;
      OP_LUI:    op_class = CLS_LUI;
      OP_AUIPC:  op_class = CLS_AUIPC;
      default:   op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV-style control FSM: FETCH/DECODE/EXEC/MEM/WB with an absorbing
// TRAP state for illegal opcodes and memory timeouts, plus a retire counter.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  input  logic                branch_taken,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          wb_sel,
  output logic [1:0]          alu_op,
  output logic                illegal,
  output logic                timeout_err,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_count,
  output logic [2:0]          dbg_state
);

  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam int              WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  class_e              cls_q, cls_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  logic [RETIRE_W-1:0] count_q, count_d;

  logic [3:0] cls_raw;
  class_e     cls_dec;
  logic       wait_expired;
  logic       mem_state;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (cls_raw)
  );

  assign cls_dec = class_e'(cls_raw);

  // Handshake: mem_req stays high from the first FETCH/MEM cycle until a cycle
  // with mem_ready=1; that cycle completes the access and the FSM moves on.
  // mem_ready in the cycle the wait count hits the limit still completes it.
  assign mem_state    = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_expired = TIMEOUT_EN && mem_state && !mem_ready && (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_DECODE: begin
        cls_d = cls_dec;
        if (cls_dec == CLS_ILLEGAL) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_q == CLS_BRANCH)      state_d = ST_FETCH;
        else if (is_mem_class(cls_q)) state_d = ST_MEM;
        else                          state_d = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
        end else if (wait_expired) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  // The wait count restarts whenever the FSM enters a new state, so it only
  // accumulates across consecutive stalled FETCH or MEM cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_state && !mem_ready && (wait_q != '1)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (retire) count_d = count_q + 1'b1;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_FUNCT;
          end
          CLS_IMM: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
          end
          CLS_BRANCH: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_BRANCH;
            pc_write  = branch_taken;
            retire    = 1'b1;
          end
          CLS_JAL: begin
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_IMM;
            pc_write  = 1'b1;
          end
          CLS_LUI: begin
            alu_src_a = SRC_A_ZERO;
            alu_src_b = SRC_B_IMM;
          end
          CLS_AUIPC: begin
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_IMM;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        retire  = (cls_q == CLS_STORE) && mem_ready;
      end
      ST_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (cls_q == CLS_LOAD)     wb_sel = WB_MEM;
        else if (cls_q == CLS_JAL) wb_sel = WB_PC4;
      end
      default: ;
    endcase
    // Reset has already forced FETCH; gating here drops the request at once.
    if (!rst_n) begin
      mem_req  = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      retire   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_ILLEGAL;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign illegal      = illegal_q;
  assign timeout_err  = timeout_q;
  assign retire_count = count_q;
  assign dbg_state    = state_q;

endmodule
